// File: rtl/conv_seq_ctrl.sv
// Sequencing controller for the 1-D convolution Z[i] = sum_j X[j]*Y[i-j].
// Walks MEMX/MEMY, drives the MAC enables and writes each Z[i] to MEMOUT_Z.
module conv_seq_ctrl #(
   parameter int unsigned ADDR_WIDTH_IN  = 5,
   parameter int unsigned ADDR_WIDTH_OUT = 6,
   parameter int unsigned DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic [DATA_WIDTH-1:0]     config_word,
   output logic [ADDR_WIDTH_IN-1:0]  memX_addr,
   output logic [ADDR_WIDTH_IN-1:0]  memY_addr,
   output logic                      mac_clr,
   output logic                      mac_en,
   output logic [ADDR_WIDTH_OUT-1:0] memZ_addr,
   output logic                      writeZ,
   output logic                      busy_out,
   output logic                      done_out
);

   localparam int unsigned AW = ADDR_WIDTH_IN;
   localparam int unsigned W  = ADDR_WIDTH_OUT;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StMac   = 3'd1;
   localparam logic [2:0] StWait  = 3'd2;
   localparam logic [2:0] StWrite = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   localparam logic [W-1:0] One = W'(1);
   localparam logic [W-1:0] Two = W'(2);

   logic [2:0]   state_q, state_d;
   logic [W-1:0] size_x_q, size_x_d, size_y_q, size_y_d;
   logic [W-1:0] i_q, i_d, j_q, j_d;
   logic [W-1:0] cfg_x, cfg_y, j_hi, i_next, j_lo_next, last_i, y_idx;
   logic         first_q;
   logic         unused_bits;

   assign cfg_x = {{(W-AW){1'b0}}, config_word[AW-1:0]};
   assign cfg_y = {{(W-AW){1'b0}}, config_word[2*AW-1:AW]};
   assign unused_bits = ^{config_word[DATA_WIDTH-1:2*AW], y_idx[W-1:AW]};

   // All index arithmetic runs at the output width, so i+1 and sizeX+sizeY never wrap.
   always_comb begin
      j_hi      = (i_q < size_x_q - One) ? i_q : size_x_q - One;
      i_next    = i_q + One;
      j_lo_next = (i_next + One > size_y_q) ? (i_next + One - size_y_q) : '0;
      last_i    = size_x_q + size_y_q - Two;
   end

   always_comb begin
      state_d  = state_q;
      size_x_d = size_x_q;
      size_y_d = size_y_q;
      i_d      = i_q;
      j_d      = j_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               size_x_d = cfg_x;
               size_y_d = cfg_y;
               i_d      = '0;
               j_d      = '0;
               state_d  = (cfg_x == '0 || cfg_y == '0) ? StDone : StMac;
            end
         end
         StMac: begin
            if (j_q == j_hi) state_d = StWait;
            else             j_d = j_q + One;
         end
         StWait: state_d = StWrite;
         StWrite: begin
            if (i_q == last_i) begin
               state_d = StDone;
            end else begin
               i_d     = i_next;
               j_d     = j_lo_next;
               state_d = StMac;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign y_idx = i_d - j_d;

   // Outputs are registered from next-state values so they line up with state_q.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         size_x_q  <= '0;
         size_y_q  <= '0;
         i_q       <= '0;
         j_q       <= '0;
         first_q   <= 1'b0;
         memX_addr <= '0;
         memY_addr <= '0;
         mac_clr   <= 1'b0;
         mac_en    <= 1'b0;
         memZ_addr <= '0;
         writeZ    <= 1'b0;
         busy_out  <= 1'b0;
         done_out  <= 1'b0;
      end else begin
         state_q  <= state_d;
         size_x_q <= size_x_d;
         size_y_q <= size_y_d;
         i_q      <= i_d;
         j_q      <= j_d;
         first_q  <= (state_d == StMac) && (state_q != StMac);
         // MAC enables trail the address cycle by the one-cycle memory latency.
         mac_en   <= (state_q == StMac);
         mac_clr  <= (state_q == StMac) && first_q;
         if (state_d == StMac) begin
            memX_addr <= j_d[AW-1:0];
            memY_addr <= y_idx[AW-1:0];
         end
         if (state_d == StWrite) memZ_addr <= i_d;
         writeZ   <= (state_d == StWrite);
         busy_out <= (state_d == StMac) || (state_d == StWait) || (state_d == StWrite);
         done_out <= (state_d == StDone);
      end
   end

endmodule
